// File: rtl/cp0_exc_pkg.sv
// Shared CP0 constants: register indices, exception codes, status bit
// positions and the decoder opcode/funct values that raise CP0 requests.
package cp0_exc_pkg;

    // CP0 register indices
    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    // Cause.ExcCode values
    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_RI  = 5'd10;

    // Status bit positions
    localparam int unsigned STATUS_IE  = 0;
    localparam int unsigned STATUS_KUP = 3;
    localparam int unsigned STATUS_UM  = 4;

    // Cause.ExcCode field position
    localparam int unsigned CAUSE_CODE_LSB = 2;

    // Decoder encodings that feed the CP0 request lines
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_COP0    = 6'b010000;
    localparam logic [5:0] FN_SYSCALL = 6'b001100;
    localparam logic [5:0] FN_ERET    = 6'b011000;
    localparam logic [4:0] RS_MFC0    = 5'b00000;
    localparam logic [4:0] RS_MTC0    = 5'b00100;

    // Controller states
    typedef enum logic {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } state_e;

    // Action chosen by the request arbiter in a given cycle
    typedef enum logic [1:0] {
        ACT_NONE  = 2'd0,
        ACT_EXC   = 2'd1,
        ACT_RET   = 2'd2,
        ACT_WRITE = 2'd3
    } act_e;

    // Pack the architecturally visible status bits into a 32-bit word
    function automatic logic [31:0] pack_status(input logic ie,
                                                input logic kup,
                                                input logic um);
        logic [31:0] w;
        w = '0;
        w[STATUS_IE]  = ie;
        w[STATUS_KUP] = kup;
        w[STATUS_UM]  = um;
        return w;
    endfunction

    // Pack the exception code into a 32-bit cause word
    function automatic logic [31:0] pack_cause(input logic [4:0] code);
        logic [31:0] w;
        w = '0;
        w[CAUSE_CODE_LSB +: 5] = code;
        return w;
    endfunction

endpackage

// File: rtl/cp0_exc.sv
// CP0 exception controller: status/cause/epc registers, exception and
// return arbitration, fetch redirect and pipeline flush sequencing.
// Optional external interrupt support is enabled by defining CP0_IRQ_EN.
module cp0_exc
    import cp0_exc_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 3,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic        exc_ri,
    input  logic        exc_sys,
    input  logic        exc_ret,
    input  logic        cowrite,
    input  logic [4:0]  cp_addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
`ifdef CP0_IRQ_EN
    input  logic        irq,
`endif
    output logic        user_mode,
    output logic [31:0] rdata,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_e      state_q;
    logic [3:0]  cnt_q;

    logic        ie_q,   ie_d;
    logic        kup_q,  kup_d;
    logic        um_q,   um_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] epc_q,  epc_d;

    act_e        act;
    logic [4:0]  exc_code;
    logic        irq_req;

`ifdef CP0_IRQ_EN
    // Interrupt is only a candidate when globally enabled
    assign irq_req = irq & ie_q;
`else
    assign irq_req = 1'b0;
`endif

    // Arbitrate the requests of the instruction in execute
    always_comb begin
        act      = ACT_NONE;
        exc_code = EXC_SYS;
        if (!reset && (state_q == S_RUN) && valid) begin
            if (irq_req) begin
                act      = ACT_EXC;
                exc_code = EXC_INT;
            end else if (exc_ri) begin
                act      = ACT_EXC;
                exc_code = EXC_RI;
            end else if (exc_sys) begin
                act      = ACT_EXC;
                exc_code = EXC_SYS;
            end else if (exc_ret) begin
                act      = ACT_RET;
            end else if (cowrite) begin
                act      = ACT_WRITE;
            end
        end
    end

    // Redirect fires in the cycle the winning request is sampled
    always_comb begin
        redirect    = (act == ACT_EXC) || (act == ACT_RET);
        redirect_pc = (act == ACT_RET) ? epc_q : EXC_VECTOR;
        flush       = !reset && (redirect || (state_q == S_FLUSH));
    end

    // Next values of the CP0 registers for the chosen action
    always_comb begin
        ie_d   = ie_q;
        kup_d  = kup_q;
        um_d   = um_q;
        code_d = code_q;
        epc_d  = epc_q;
        unique case (act)
            ACT_EXC: begin
                epc_d  = pc;
                code_d = exc_code;
                kup_d  = um_q;
                um_d   = 1'b0;
                ie_d   = 1'b0;
            end
            ACT_RET: begin
                um_d   = kup_q;
                ie_d   = 1'b1;
            end
            ACT_WRITE: begin
                if (cp_addr == CP0_STATUS) begin
                    ie_d  = wdata[STATUS_IE];
                    kup_d = wdata[STATUS_KUP];
                    um_d  = wdata[STATUS_UM];
                end else if (cp_addr == CP0_EPC) begin
                    epc_d = wdata;
                end
            end
            default: ;
        endcase
    end

    // CP0 register file update
    always_ff @(posedge clk) begin
        if (reset) begin
            ie_q   <= 1'b0;
            kup_q  <= 1'b0;
            um_q   <= 1'b0;
            code_q <= '0;
            epc_q  <= '0;
        end else begin
            ie_q   <= ie_d;
            kup_q  <= kup_d;
            um_q   <= um_d;
            code_q <= code_d;
            epc_q  <= epc_d;
        end
    end

    // RUN/FLUSH controller; the counter holds the remaining flush cycles,
    // so leaving FLUSH happens on the cycle it steps from 1 to 0
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (redirect) begin
                        state_q <= S_FLUSH;
                        cnt_q   <= FLUSH_LOAD;
                    end
                end
                S_FLUSH: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                    if (cnt_q <= 4'd1) begin
                        state_q <= S_RUN;
                    end
                end
                default: begin
                    state_q <= S_RUN;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Combinational register read port
    always_comb begin
        unique case (cp_addr)
            CP0_STATUS: rdata = pack_status(ie_q, kup_q, um_q);
            CP0_CAUSE:  rdata = pack_cause(code_q);
            CP0_EPC:    rdata = epc_q;
            default:    rdata = '0;
        endcase
    end

    // Current mode back to the decoder
    always_comb begin
        user_mode = um_q;
    end

endmodule

// File: tb/tb_cp0_exc.sv
// Self-checking bench for cp0_exc: a behavioural CP0 model predicts the
// outputs of every cycle into a scoreboard queue that is drained against
// the DUT before the next clock edge. Build with CP0_IRQ_EN to exercise
// the interrupt arm.
module tb_cp0_exc;

    localparam int unsigned FC  = 3;
    localparam logic [31:0] VEC = 32'h0000_0080;
`ifdef CP0_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, valid, exc_ri, exc_sys, exc_ret, cowrite, irq;
    logic [4:0]  cp_addr;
    logic [31:0] wdata, pc;
    logic        user_mode, redirect, flush;
    logic [31:0] rdata, redirect_pc;

    cp0_exc #(
        .FLUSH_CYCLES(FC),
        .EXC_VECTOR  (VEC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .valid      (valid),
        .exc_ri     (exc_ri),
        .exc_sys    (exc_sys),
        .exc_ret    (exc_ret),
        .cowrite    (cowrite),
        .cp_addr    (cp_addr),
        .wdata      (wdata),
        .pc         (pc),
`ifdef CP0_IRQ_EN
        .irq        (irq),
`endif
        .user_mode  (user_mode),
        .rdata      (rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .flush      (flush)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    bit          m_ie, m_kup, m_um;
    logic [4:0]  m_code;
    logic [31:0] m_epc;
    int          m_cnt;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mread(input logic [4:0] a);
        case (a)
            5'd12:   return {27'd0, m_um, m_kup, 2'b00, m_ie};
            5'd13:   return {25'd0, m_code, 2'b00};
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] observe(input string tag);
        if (tag == "redirect")    return {31'd0, redirect};
        if (tag == "flush")       return {31'd0, flush};
        if (tag == "user_mode")   return {31'd0, user_mode};
        if (tag == "redirect_pc") return redirect_pc;
        return rdata;
    endfunction

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq(e.tag, observe(e.tag), e.val);
        end
    endtask

    // One clock cycle: drive, predict, compare, clock, advance the model
    task automatic cycle(input bit v, input bit ri, input bit sys, input bit ret,
                         input bit cw, input bit rst, input logic [4:0] a,
                         input logic [31:0] wd, input logic [31:0] pcv, input bit iq);
        bit         busy, take_irq, take_exc, take_ret;
        logic [4:0] code;
        valid = v; exc_ri = ri; exc_sys = sys; exc_ret = ret; cowrite = cw;
        reset = rst; cp_addr = a; wdata = wd; pc = pcv; irq = iq;

        busy     = (m_cnt > 0);
        take_irq = IRQ_EN && iq && m_ie;
        take_exc = !rst && !busy && v && (take_irq || ri || sys);
        take_ret = !rst && !busy && v && !take_exc && ret;
        code     = take_irq ? 5'd0 : (ri ? 5'd10 : 5'd8);

        push("redirect",  {31'd0, take_exc || take_ret});
        push("flush",     {31'd0, !rst && (busy || take_exc || take_ret)});
        push("user_mode", {31'd0, m_um});
        push("rdata",     mread(a));
        if (take_exc)      push("redirect_pc", VEC);
        else if (take_ret) push("redirect_pc", m_epc);

        #3;
        drain();
        @(posedge clk);
        #1;

        if (rst) begin
            m_ie = 0; m_kup = 0; m_um = 0; m_code = '0; m_epc = '0; m_cnt = 0;
        end else if (busy) begin
            m_cnt--;
        end else if (take_exc) begin
            m_epc = pcv; m_code = code; m_kup = m_um; m_um = 0; m_ie = 0; m_cnt = FC;
        end else if (take_ret) begin
            m_um = m_kup; m_ie = 1; m_cnt = FC;
        end else if (v && cw) begin
            if (a == 5'd12) begin
                m_ie = wd[0]; m_kup = wd[3]; m_um = wd[4];
            end else if (a == 5'd14) begin
                m_epc = wd;
            end
        end
    endtask

    task automatic idle(input logic [4:0] a);
        cycle(0, 0, 0, 0, 0, 0, a, 32'd0, 32'd0, 0);
    endtask

    task automatic cowr(input logic [4:0] a, input logic [31:0] wd);
        cycle(1, 0, 0, 0, 1, 0, a, wd, 32'h0000_0100, 0);
    endtask

    // Flush window with conflicting requests that must all be ignored
    task automatic flush_window();
        for (int i = 0; i < int'(FC); i++)
            cycle(1, 1, 1, 1, 1, 0, 5'd14, 32'h0000_0BAD, 32'h0000_0900, 1);
    endtask

    // Mid-cycle combinational read of one CP0 register against a constant
    task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] expv);
        valid = 0; cowrite = 0; exc_ri = 0; exc_sys = 0; exc_ret = 0; irq = 0;
        cp_addr = a;
        #1;
        check_eq(tag, rdata, expv);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1; valid = 0; exc_ri = 0; exc_sys = 0; exc_ret = 0; cowrite = 0;
        irq = 0; cp_addr = '0; wdata = '0; pc = '0;
        m_ie = 0; m_kup = 0; m_um = 0; m_code = '0; m_epc = '0; m_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;

        // Reset state
        check_eq("rst_flush", {31'd0, flush}, 32'd0);
        peek("rst_status", 5'd12, 32'd0);
        peek("rst_cause",  5'd13, 32'd0);
        peek("rst_epc",    5'd14, 32'd0);

        // Enter user mode by writing status; cause writes are dropped
        cowr(5'd12, 32'h0000_0010);
        peek("status_user", 5'd12, 32'h0000_0010);
        check_eq("user_mode_set", {31'd0, user_mode}, 32'd1);
        cowr(5'd13, 32'h0000_00FF);
        peek("cause_nowrite", 5'd13, 32'd0);

        // Syscall from user mode, then the flush window with ignored requests
        cycle(1, 0, 1, 0, 0, 0, 5'd14, 32'd0, 32'h0000_0400, 0);
        flush_window();
        idle(5'd12);
        peek("sys_epc",    5'd14, 32'h0000_0400);
        peek("sys_cause",  5'd13, 32'h0000_0020);
        peek("sys_status", 5'd12, 32'h0000_0008);

        // Return to user mode
        cycle(1, 0, 0, 1, 0, 0, 5'd12, 32'd0, 32'h0000_0480, 0);
        flush_window();
        peek("ret_status", 5'd12, 32'h0000_0019);
        check_eq("ret_user_mode", {31'd0, user_mode}, 32'd1);
        peek("ret_epc",    5'd14, 32'h0000_0400);

        // RI beats syscall, return and a simultaneous epc write
        cycle(1, 1, 1, 1, 1, 0, 5'd14, 32'h0000_DEAD, 32'h0000_0500, 0);
        flush_window();
        peek("ri_cause",  5'd13, 32'h0000_0028);
        peek("ri_epc",    5'd14, 32'h0000_0500);
        peek("ri_status", 5'd12, 32'h0000_0008);

        // Nested syscall from kernel mode clears KUp
        cycle(1, 0, 1, 0, 0, 0, 5'd13, 32'd0, 32'h0000_0600, 0);
        flush_window();
        peek("nest_status", 5'd12, 32'h0000_0000);
        peek("nest_epc",    5'd14, 32'h0000_0600);

        // Requests without valid are ignored
        cycle(0, 1, 1, 1, 1, 0, 5'd14, 32'h1234_5678, 32'h0000_0680, 0);
        idle(5'd14);

        // Reset on the second flush cycle aborts the flush
        cowr(5'd12, 32'h0000_0011);
        cycle(1, 0, 1, 0, 0, 0, 5'd14, 32'd0, 32'h0000_0700, 0);
        idle(5'd14);
        cycle(0, 0, 0, 0, 0, 1, 5'd12, 32'd0, 32'd0, 0);
        check_eq("abort_flush", {31'd0, flush}, 32'd0);
        peek("abort_status", 5'd12, 32'd0);
        cycle(1, 0, 1, 0, 0, 0, 5'd14, 32'd0, 32'h0000_0704, 0);
        flush_window();
        peek("abort_epc", 5'd14, 32'h0000_0704);

        // Interrupt arm: taken only with IE set and the feature built in
        cowr(5'd12, 32'h0000_0001);
        cycle(1, 0, 1, 0, 0, 0, 5'd13, 32'd0, 32'h0000_0800, 1);
        flush_window();
        peek("irq_cause", 5'd13, IRQ_EN ? 32'h0000_0000 : 32'h0000_0020);
        peek("irq_epc",   5'd14, 32'h0000_0800);
        cycle(1, 0, 0, 0, 0, 0, 5'd13, 32'd0, 32'h0000_0840, 1);
        idle(5'd13);

        // Status write masking and unimplemented indices
        cowr(5'd12, 32'hFFFF_FFFF);
        peek("status_mask", 5'd12, 32'h0000_0019);
        peek("unimpl_5",    5'd5,  32'd0);
        idle(5'd15);
        peek("unimpl_31",   5'd31, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
